// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - burst frame sequencer between TX source/RX sink and SPI FIFOs; optional watchdog via SPI_SEQ_WATCHDOG_EN
module spi_frame_sequencer #(
   parameter int CFG_FRAME_SIZE = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CNT_WIDTH-1:0]      frame_cnt,
   input  logic [CFG_FRAME_SIZE-1:0] src_data,
   input  logic                      src_valid,
   output logic                      src_ready,
   input  logic                      apb_tx_write,
   input  logic [CFG_FRAME_SIZE-1:0] apb_tx_data,
   input  logic                      apb_tx_last,
   input  logic                      apb_rx_read,
   input  logic                      tx_fifo_full,
   input  logic                      rx_fifo_empty,
   input  logic [CFG_FRAME_SIZE-1:0] rx_fifo_data,
   output logic [CFG_FRAME_SIZE-1:0] tx_fifo_data,
   output logic                      tx_fifo_write,
   output logic                      tx_fifo_last,
   output logic                      rx_fifo_read,
   output logic [CFG_FRAME_SIZE-1:0] sink_data,
   output logic                      sink_valid,
   input  logic                      sink_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] tx_rem_q, tx_rem_d;
   logic [CNT_WIDTH-1:0] rx_rem_q, rx_rem_d;
   logic                 in_run;
   logic                 wd_expired;
   logic                 seq_tx;
   logic                 seq_rx;

   // Reset is synchronous, so the old state is still visible during the reset
   // cycle; gating with preset keeps every sequencer-driven output quiet then.
   assign in_run = (state_q == ST_RUN) && !preset;

   assign seq_tx = in_run && src_valid && !tx_fifo_full && (tx_rem_q != '0)
                   && !apb_tx_write && !abort && !wd_expired;
   assign seq_rx = in_run && !rx_fifo_empty && sink_ready && (rx_rem_q != '0)
                   && !apb_rx_read && !abort && !wd_expired;

   assign busy    = (state_q != ST_IDLE) && !preset;
   assign done    = (state_q == ST_DONE) && !preset;
   assign timeout = wd_expired;

`ifdef SPI_SEQ_WATCHDOG_EN
   logic [7:0] wd_q, wd_d;

   assign wd_expired = in_run && !abort && (wd_q == 8'hFF);

   // Watchdog counts consecutive RUN cycles with no progress and no state change
   always_comb begin
      wd_d = 8'd0;
      if (in_run && (state_d == ST_RUN) && !seq_tx && !seq_rx) begin
         wd_d = wd_q + 8'd1;
      end
   end

   // Watchdog register
   always_ff @(posedge pclk) begin
      if (preset) begin
         wd_q <= 8'd0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   // TX port mux: register-side writes always take the port over the sequencer
   always_comb begin
      tx_fifo_write = 1'b0;
      tx_fifo_data  = '0;
      tx_fifo_last  = 1'b0;
      src_ready     = 1'b0;
      if (apb_tx_write) begin
         tx_fifo_write = 1'b1;
         tx_fifo_data  = apb_tx_data;
         tx_fifo_last  = apb_tx_last;
      end else if (seq_tx) begin
         tx_fifo_write = 1'b1;
         tx_fifo_data  = src_data;
         tx_fifo_last  = (tx_rem_q == CNT_WIDTH'(1));
         src_ready     = 1'b1;
      end
   end

   // RX port mux: register-side reads pop the FIFO without presenting to the sink
   always_comb begin
      rx_fifo_read = 1'b0;
      sink_valid   = 1'b0;
      sink_data    = '0;
      if (apb_rx_read) begin
         rx_fifo_read = 1'b1;
      end else if (seq_rx) begin
         rx_fifo_read = 1'b1;
         sink_valid   = 1'b1;
         sink_data    = rx_fifo_data;
      end
   end

   // Next-state and remaining-frame counters; abort/timeout beat completion and transfers
   always_comb begin
      state_d  = state_q;
      tx_rem_d = tx_rem_q;
      rx_rem_d = rx_rem_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (frame_cnt != '0)) begin
               state_d  = ST_RUN;
               tx_rem_d = frame_cnt;
               rx_rem_d = frame_cnt;
            end
         end
         ST_RUN: begin
            if (abort || wd_expired) begin
               state_d  = ST_IDLE;
               tx_rem_d = '0;
               rx_rem_d = '0;
            end else if ((tx_rem_q == '0) && (rx_rem_q == '0)) begin
               state_d = ST_DONE;
            end else begin
               if (seq_tx) begin
                  tx_rem_d = tx_rem_q - CNT_WIDTH'(1);
               end
               if (seq_rx) begin
                  rx_rem_d = rx_rem_q - CNT_WIDTH'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q  <= ST_IDLE;
         tx_rem_q <= '0;
         rx_rem_q <= '0;
      end else begin
         state_q  <= state_d;
         tx_rem_q <= tx_rem_d;
         rx_rem_q <= rx_rem_d;
      end
   end

endmodule

// File: doc/spi_frame_sequencer.md
SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 Parameter CFG_FRAME_SIZE, default 4, SHALL set the frame data width in bits.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the burst frame-count width.
REQ-003 pclk  in  1  sole clock; all state changes on rising edge.
REQ-004 preset  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  one-cycle burst request; sampled only in IDLE.
REQ-006 abort  in  1  cancels the active burst.
REQ-007 frame_cnt  in  CNT_WIDTH  frames per burst; sampled when start is accepted.
REQ-008 src_data  in  CFG_FRAME_SIZE  and src_valid in 1: streaming TX source.
REQ-009 src_ready  out  1  source frame consumed this cycle.
REQ-010 apb_tx_write  in  1, apb_tx_data  in  CFG_FRAME_SIZE, apb_tx_last  in  1: register-side TX FIFO write.
REQ-011 apb_rx_read  in  1  register-side RX FIFO read.
REQ-012 tx_fifo_full  in  1, rx_fifo_empty  in  1, rx_fifo_data  in  CFG_FRAME_SIZE (first-word-fall-through): FIFO status/data.
REQ-013 tx_fifo_data  out  CFG_FRAME_SIZE, tx_fifo_write  out  1, tx_fifo_last  out  1, rx_fifo_read  out  1: FIFO strobes.
REQ-014 sink_data  out  CFG_FRAME_SIZE, sink_valid  out  1, sink_ready  in  1: RX drain sink.
REQ-015 busy  out  1, done  out  1 (one-cycle pulse), timeout  out  1 (one-cycle pulse).

Function
REQ-016 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start with frame_cnt!=0, loading tx_rem and rx_rem with frame_cnt.
REQ-017 start with frame_cnt==0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-018 RUN->DONE when tx_rem==0 and rx_rem==0; DONE->IDLE unconditionally next cycle, done=1 in DONE only.
REQ-019 abort in RUN SHALL force IDLE next cycle, clear counters, no done pulse; abort has priority over all other RUN events.
REQ-020 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-021 Sequencer TX write in cycle N iff RUN, src_valid, !tx_fifo_full, tx_rem!=0, !apb_tx_write, !abort; then src_ready=1, tx_fifo_write=1, tx_fifo_data=src_data, tx_rem decrements.
REQ-022 tx_fifo_last SHALL be 1 on the sequencer write where tx_rem==1, else 0 for sequencer writes.
REQ-023 apb_tx_write SHALL always win the TX port: tx_fifo_write=1, data/last from apb_tx_*, src_ready=0, tx_rem unchanged, in any state.
REQ-024 Sequencer RX read iff RUN, !rx_fifo_empty, sink_ready, rx_rem!=0, !apb_rx_read, !abort; then rx_fifo_read=1, sink_valid=1, sink_data=rx_fifo_data, rx_rem decrements.
REQ-025 apb_rx_read SHALL always win: rx_fifo_read=1, sink_valid=0, rx_rem unchanged.
REQ-026 TX and RX paths SHALL operate independently in the same cycle; zero-latency combinational strobes, registered counters/state.
REQ-027 Counters SHALL never wrap: no decrement at 0; tx_fifo_full or rx_fifo_empty stalls without loss.
REQ-028 Outside RUN src_ready, sink_valid and sequencer strobes SHALL be 0.

Reset
REQ-029 preset=1 SHALL, at the clock edge, force IDLE, tx_rem=rx_rem=0, watchdog=0; this overrides start/abort and applies mid-burst.
REQ-030 During and after reset all outputs SHALL be 0 except those driven by apb_tx_write/apb_rx_read pass-through.

Configuration
REQ-031 With SPI_SEQ_WATCHDOG_EN defined: 8-bit counter clears on any sequencer TX write/RX read or state change, increments in RUN otherwise; at 255 the block SHALL pulse timeout and go to IDLE as on abort.
REQ-032 Without SPI_SEQ_WATCHDOG_EN: no counter is built, timeout tied 0, RUN persists until completion or abort.

Verification
REQ-033 frame_cnt=3, src_valid=1, FIFOs ready, sink_ready=1 -> 3 writes, last only on 3rd, 3 reads, done pulse, busy falls.
REQ-034 apb_tx_write=1 during RUN with src_valid=1 -> APB data written, src_ready=0, tx_rem unchanged.
REQ-035 tx_fifo_full=1 for 10 cycles mid-burst frame_cnt=4 -> no writes, no loss, exactly 4 writes total.
REQ-036 abort in RUN with tx_rem=2 -> IDLE next cycle, no done, later start frame_cnt=1 works.
REQ-037 preset=1 mid-burst -> IDLE, busy=0, counters 0; start with frame_cnt=0 -> stays IDLE.
REQ-038 SPI_SEQ_WATCHDOG_EN, rx_fifo_empty=1 forever after TX -> timeout pulse at 255 idle cycles, IDLE.
